// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
//  state_e  : arbiter FSM states (idle, command issue, latency wait)
//  owner_e  : which pipeline port owns the in-flight access
//  RunW     : width of the consecutive-D-grant counter (fairness build only)
//  cnt_width: latency counter width able to hold LAT
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    typedef enum logic {
        OwnerI = 1'b0,
        OwnerD = 1'b1
    } owner_e;

    localparam int unsigned RunW = 3;

    function automatic int unsigned cnt_width(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// Memory latency counter for mem_arbiter.
// Ports:
//  clk      in  clock
//  rst      in  asynchronous active-low reset
//  load_i   in  load the counter with LAT (command accepted)
//  dec_i    in  decrement while waiting for read data
//  at_one_o out counter equals 1: memory data is valid this cycle
module lat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic at_one_o
);

    localparam int unsigned CntW = cnt_width(LAT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntW'(LAT);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_one_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port fixed-latency memory between instruction fetch (I)
// and the memory stage (D). One access in flight at a time: IDLE -> ISSUE -> WAIT -> IDLE.
// Optional fairness: define MEM_ARB_FAIR_EN to force an I grant after MAX_DATA_RUN
// consecutive D grants while I is waiting; otherwise D has strict priority.
// Ports:
//  clk, rst                 clock, asynchronous active-low reset
//  i_req/i_addr             fetch read request (held until i_done)
//  i_rdata/i_done/i_stall   fetch read data, completion pulse, freeze request
//  d_rd/d_wr/d_addr/d_wdata data request (held until d_done); rd&wr acts as write
//  d_rdata/d_done/d_stall   data read data, completion pulse, freeze request
//  mem_en/mem_wr/mem_addr/mem_wdata  command to memory
//  mem_ready                memory accepts command when mem_en & mem_ready
//  mem_rdata                read data, valid LAT cycles after accept
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned LAT          = 4,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    output logic              i_stall,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    if ((LAT < 1) || (MAX_DATA_RUN < 1) || (MAX_DATA_RUN > ((1 << RunW) - 1))) begin : g_param_check
        $error("mem_arbiter: LAT must be >= 1 and MAX_DATA_RUN must fit the run counter");
    end

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic d_req;
    logic force_i;
    logic grant_d;
    logic grant_i;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_at_one;
    logic done;

    assign d_req   = d_rd | d_wr;
    assign grant_d = (state_q == StIdle) && d_req && !force_i;
    assign grant_i = (state_q == StIdle) && i_req && !grant_d;

`ifdef MEM_ARB_FAIR_EN
    // Consecutive D grants taken while I was waiting; a grant with I idle restarts the run.
    logic [RunW-1:0] d_run_q, d_run_d;

    assign force_i = i_req && (d_run_q == RunW'(MAX_DATA_RUN));

    always_comb begin
        d_run_d = d_run_q;
        if (grant_i) begin
            d_run_d = '0;
        end else if (grant_d) begin
            d_run_d = i_req ? (d_run_q + RunW'(1)) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_run_q <= '0;
        end else begin
            d_run_q <= d_run_d;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    assign cnt_load = (state_q == StIssue) && mem_ready;
    assign cnt_dec  = (state_q == StWait);

    lat_counter #(
        .LAT(LAT)
    ) u_lat_counter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load),
        .dec_i   (cnt_dec),
        .at_one_o(cnt_at_one)
    );

    // Completion is decoded from registered state only, so it never depends on live requests.
    assign done   = (state_q == StWait) && cnt_at_one;
    assign i_done = done && (owner_q == OwnerI);
    assign d_done = done && (owner_q == OwnerD);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        case (state_q)
            StIdle: begin
                if (grant_d) begin
                    owner_d = OwnerD;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    wr_d    = d_wr;
                    state_d = StIssue;
                end else if (grant_i) begin
                    owner_d = OwnerI;
                    addr_d  = i_addr;
                    wdata_d = '0;
                    wr_d    = 1'b0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (mem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_at_one) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read data is forwarded in the done cycle and held afterwards.
    always_comb begin
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (i_done) begin
            i_rdata_d = mem_rdata;
        end
        if (d_done && !wr_q) begin
            d_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            owner_q   <= OwnerI;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_rdata   = i_rdata_d;
    assign d_rdata   = d_rdata_d;
    assign mem_en    = (state_q == StIssue);
    assign mem_wr    = mem_en && wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Gated by reset so every output reads 0 while reset is held.
    assign i_stall = i_req & ~i_done & rst;
    assign d_stall = d_req & ~d_done & rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level reference model. Honours MEM_ARB_FAIR_EN like the design.
module tb_mem_arbiter;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned LAT = 4;
    localparam int unsigned MDR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          i_stall;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_stall;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Memory model: 256 words, reads return data exactly LAT cycles after accept.
    logic [DW-1:0] mem [256];
    int            due_q[$];
    logic [DW-1:0] rd_q[$];

    mem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .LAT         (LAT),
        .MAX_DATA_RUN(MDR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_done   (i_done),
        .i_stall  (i_stall),
        .d_rd     (d_rd),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .d_stall  (d_stall),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one clock; apply memory side effects of a command accepted in the old cycle.
    task automatic tick();
        logic          acc;
        logic          acc_wr;
        logic [AW-1:0] acc_addr;
        logic [DW-1:0] acc_wdata;
        acc       = mem_en & mem_ready;
        acc_wr    = mem_wr;
        acc_addr  = mem_addr;
        acc_wdata = mem_wdata;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            if (acc_wr) begin
                mem[acc_addr[7:0]] = acc_wdata;
            end else begin
                due_q.push_back(cyc - 1 + int'(LAT));
                rd_q.push_back(mem[acc_addr[7:0]]);
            end
        end
        while (due_q.size() > 0 && due_q[0] < cyc) begin
            void'(due_q.pop_front());
            void'(rd_q.pop_front());
        end
        mem_rdata = 16'($urandom);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            mem_rdata = rd_q.pop_front();
            void'(due_q.pop_front());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; i_req = 1'b1; d_rd = 1'b1; d_wr = 1'b0;
        i_addr = 16'h0001; d_addr = 16'h0002; d_wdata = 16'h0003; mem_ready = 1'b1;
        tick();
        tick();
        #1;
        n_checks++;
        if ({mem_en, mem_wr, mem_addr, mem_wdata} !== 34'd0) begin
            n_errors++;
            $display("FAIL reset_mem_cmd got %h want 0", {mem_en, mem_wr, mem_addr, mem_wdata});
        end
        n_checks++;
        if ({i_done, d_done, i_stall, d_stall} !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_flags got %b want 0000", {i_done, d_done, i_stall, d_stall});
        end
        n_checks++;
        if ({i_rdata, d_rdata} !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_rdata got %h want 0", {i_rdata, d_rdata});
        end
        i_req = 1'b0; d_rd = 1'b0;
        #1;
        rst = 1'b1;
        tick();
        #1;
        n_checks++;
        if (mem_en !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_no_req mem_en got %b want 0", mem_en);
        end
    endtask

    task automatic test_single_read();
        mem[8'h40] = 16'hBEEF;
        i_req = 1'b1; i_addr = 16'h0040; mem_ready = 1'b1;
        for (int t = 0; t < 9; t++) begin
            if (t > 0) tick();
            if (t == 6) i_req = 1'b0;
            #1;
            n_checks++;
            if (i_done !== (t == 5)) begin
                n_errors++;
                $display("FAIL single_i_done t=%0d got %b want %b", t, i_done, (t == 5));
            end
            n_checks++;
            if (i_stall !== (t < 5)) begin
                n_errors++;
                $display("FAIL single_i_stall t=%0d got %b want %b", t, i_stall, (t < 5));
            end
            n_checks++;
            if (mem_en !== (t == 1)) begin
                n_errors++;
                $display("FAIL single_mem_en t=%0d got %b want %b", t, mem_en, (t == 1));
            end
            if (t >= 5) begin
                n_checks++;
                if (i_rdata !== 16'hBEEF) begin
                    n_errors++;
                    $display("FAIL single_i_rdata t=%0d got %h want beef", t, i_rdata);
                end
            end
        end
    endtask

    // D wins the shared cycle; I is granted after one idle cycle following d_done.
    task automatic test_d_priority();
        mem[8'h20] = 16'h2222;
        d_wr = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
        i_req = 1'b1; i_addr = 16'h0020; mem_ready = 1'b1;
        for (int t = 0; t < 13; t++) begin
            if (t > 0) tick();
            if (t == 6) d_wr = 1'b0;
            if (t == 12) i_req = 1'b0;
            #1;
            n_checks++;
            if ({d_done, i_done} !== {(t == 5), (t == 11)}) begin
                n_errors++;
                $display("FAIL prio_done t=%0d got d%b i%b want d%b i%b", t, d_done, i_done,
                         (t == 5), (t == 11));
            end
            n_checks++;
            if (mem_en !== (t == 1 || t == 7)) begin
                n_errors++;
                $display("FAIL prio_mem_en t=%0d got %b want %b", t, mem_en, (t == 1 || t == 7));
            end
            n_checks++;
            if ({d_stall, i_stall} !== {(t < 5), (t < 11)}) begin
                n_errors++;
                $display("FAIL prio_stall t=%0d got %b%b want %b%b", t, d_stall, i_stall,
                         (t < 5), (t < 11));
            end
            if (t == 1) begin
                n_checks++;
                if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'h0010, 16'h1234}) begin
                    n_errors++;
                    $display("FAIL prio_d_cmd got %b %h %h want 1 0010 1234", mem_wr, mem_addr,
                             mem_wdata);
                end
            end
            if (t == 7) begin
                n_checks++;
                if ({mem_wr, mem_addr} !== {1'b0, 16'h0020}) begin
                    n_errors++;
                    $display("FAIL prio_i_cmd got %b %h want 0 0020", mem_wr, mem_addr);
                end
            end
            if (t == 11) begin
                n_checks++;
                if (i_rdata !== 16'h2222) begin
                    n_errors++;
                    $display("FAIL prio_i_rdata got %h want 2222", i_rdata);
                end
            end
        end
        n_checks++;
        if (mem[8'h10] !== 16'h1234) begin
            n_errors++;
            $display("FAIL prio_mem_written got %h want 1234", mem[8'h10]);
        end
    endtask

    task automatic test_ready_stall();
        mem[8'h60] = 16'h6060; mem[8'h61] = 16'h6161;
        i_req = 1'b1; i_addr = 16'h0060;
        for (int t = 0; t < 11; t++) begin
            if (t > 0) tick();
            mem_ready = !(t >= 1 && t <= 3);
            if (t == 2) i_addr = 16'h0061;
            if (t == 9) i_req = 1'b0;
            #1;
            n_checks++;
            if (mem_en !== (t >= 1 && t <= 4)) begin
                n_errors++;
                $display("FAIL rdy_mem_en t=%0d got %b want %b", t, mem_en, (t >= 1 && t <= 4));
            end
            if (t >= 1 && t <= 4) begin
                n_checks++;
                if (mem_addr !== 16'h0060) begin
                    n_errors++;
                    $display("FAIL rdy_mem_addr t=%0d got %h want 0060", t, mem_addr);
                end
            end
            n_checks++;
            if (i_done !== (t == 8)) begin
                n_errors++;
                $display("FAIL rdy_i_done t=%0d got %b want %b", t, i_done, (t == 8));
            end
            if (t == 8) begin
                n_checks++;
                if (i_rdata !== 16'h6060) begin
                    n_errors++;
                    $display("FAIL rdy_i_rdata got %h want 6060", i_rdata);
                end
            end
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic seen;
        mem[8'h33] = 16'h3333; mem[8'h34] = 16'h3434;
        d_rd = 1'b1; d_addr = 16'h0033;
        for (int t = 0; t < 4; t++) begin
            if (t > 0) tick();
            #1;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_en, d_done, i_done, d_stall} !== 4'd0) begin
            n_errors++;
            $display("FAIL midrst_flags got %b want 0000", {mem_en, d_done, i_done, d_stall});
        end
        n_checks++;
        if ({i_rdata, d_rdata} !== 32'd0) begin
            n_errors++;
            $display("FAIL midrst_rdata got %h want 0", {i_rdata, d_rdata});
        end
        tick();
        d_rd = 1'b0;
        #1;
        rst = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            #1;
            if (d_done || i_done || mem_en) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_abandoned got activity=%b want 0", seen);
        end
        d_rd = 1'b1; d_addr = 16'h0034;
        for (int t = 0; t < 7; t++) begin
            if (t > 0) tick();
            if (t == 6) d_rd = 1'b0;
            #1;
            n_checks++;
            if (d_done !== (t == 5)) begin
                n_errors++;
                $display("FAIL midrst_new_done t=%0d got %b want %b", t, d_done, (t == 5));
            end
            if (t >= 5) begin
                n_checks++;
                if (d_rdata !== 16'h3434) begin
                    n_errors++;
                    $display("FAIL midrst_new_rdata got %h want 3434", d_rdata);
                end
            end
        end
    endtask

    task automatic test_rdwr_both();
        mem[8'h50] = 16'h5A5A;
        d_rd = 1'b1; d_addr = 16'h0050;
        for (int t = 0; t < 7; t++) begin
            if (t > 0) tick();
            if (t == 6) d_rd = 1'b0;
            #1;
        end
        n_checks++;
        if (d_rdata !== 16'h5A5A) begin
            n_errors++;
            $display("FAIL both_setup_rdata got %h want 5a5a", d_rdata);
        end
        d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h0051; d_wdata = 16'hA5A5;
        for (int t = 0; t < 7; t++) begin
            if (t > 0) tick();
            if (t == 6) begin d_rd = 1'b0; d_wr = 1'b0; end
            #1;
            if (t == 1) begin
                n_checks++;
                if ({mem_en, mem_wr, mem_addr} !== {1'b1, 1'b1, 16'h0051}) begin
                    n_errors++;
                    $display("FAIL both_cmd got %b%b %h want 11 0051", mem_en, mem_wr, mem_addr);
                end
            end
            n_checks++;
            if (d_done !== (t == 5)) begin
                n_errors++;
                $display("FAIL both_done t=%0d got %b want %b", t, d_done, (t == 5));
            end
            if (t >= 5) begin
                n_checks++;
                if (d_rdata !== 16'h5A5A) begin
                    n_errors++;
                    $display("FAIL both_rdata_held t=%0d got %h want 5a5a", t, d_rdata);
                end
            end
        end
        n_checks++;
        if (mem[8'h51] !== 16'hA5A5) begin
            n_errors++;
            $display("FAIL both_mem_written got %h want a5a5", mem[8'h51]);
        end
    endtask

    // D requests back to back while I waits; record the owner of each grant.
    task automatic test_arbitration();
        int   owners[$];
        int   exp_seq[$];
        logic i_drop;
        logic i_seen;
`ifdef MEM_ARB_FAIR_EN
        exp_seq = '{1, 1, 1, 1, 0, 1};
`else
        exp_seq = '{1, 1, 1, 1, 1, 1};
`endif
        i_drop = 1'b0; i_seen = 1'b0;
        d_rd = 1'b1; d_addr = 16'h0081; i_req = 1'b1; i_addr = 16'h0082; mem_ready = 1'b1;
        for (int t = 0; t < 60 && owners.size() < 6; t++) begin
            if (t > 0) tick();
            if (i_drop) i_req = 1'b0;
            #1;
            if (mem_en) owners.push_back((mem_addr == 16'h0081) ? 1 : 0);
            if (i_done) begin i_drop = 1'b1; i_seen = 1'b1; end
        end
        n_checks++;
        if (owners.size() != 6) begin
            n_errors++;
            $display("FAIL arb_grant_count got %0d want 6", owners.size());
        end
        for (int k = 0; k < 6; k++) begin
            if (k < owners.size()) begin
                n_checks++;
                if (owners[k] != exp_seq[k]) begin
                    n_errors++;
                    $display("FAIL arb_owner[%0d] got %0d want %0d (1=D)", k, owners[k],
                             exp_seq[k]);
                end
            end
        end
`ifndef MEM_ARB_FAIR_EN
        n_checks++;
        if (i_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL arb_starve got i_done=%b want 0", i_seen);
        end
        d_rd = 1'b0;
        i_seen = 1'b0;
        for (int t = 0; t < 20 && !i_seen; t++) begin
            tick();
            #1;
            if (i_done) i_seen = 1'b1;
        end
        n_checks++;
        if (i_seen !== 1'b1) begin
            n_errors++;
            $display("FAIL arb_i_after_d got i_done=%b want 1", i_seen);
        end
`endif
        i_req = 1'b0; d_rd = 1'b0;
        for (int t = 0; t < 8; t++) tick();
    endtask

    task automatic test_random();
        logic          m_busy;
        logic          m_own_d;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata;
        logic          m_wr;
        int            m_issue;
        int            m_acc;
        int            m_run;
        logic [DW-1:0] m_rdexp;
        logic [DW-1:0] exp_i_rdata;
        logic [DW-1:0] exp_d_rdata;
        logic          exp_en;
        logic          exp_idone;
        logic          exp_ddone;
        logic          drop_i;
        logic          drop_d;
        int            kind;

        rst = 1'b0; i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_ready = 1'b1;
        tick();
        rst = 1'b1;
        m_busy = 1'b0; m_own_d = 1'b0; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
        m_issue = 0; m_acc = -1; m_run = 0; m_rdexp = '0;
        exp_i_rdata = '0; exp_d_rdata = '0; drop_i = 1'b0; drop_d = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            tick();
            if (drop_i) begin
                i_req = 1'b0; drop_i = 1'b0;
            end else if (!i_req && $urandom_range(3) == 0) begin
                i_req = 1'b1; i_addr = 16'($urandom);
            end
            if (drop_d) begin
                d_rd = 1'b0; d_wr = 1'b0; drop_d = 1'b0;
            end else if (!d_rd && !d_wr && $urandom_range(3) == 0) begin
                kind = int'($urandom_range(3));
                d_rd = (kind <= 1) || (kind == 3);
                d_wr = (kind >= 2);
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
            mem_ready = ($urandom_range(3) != 0);
            #1;

            // Grant: one access at a time, D first unless fairness forces I.
            if (!m_busy && (i_req || d_rd || d_wr)) begin
`ifdef MEM_ARB_FAIR_EN
                m_own_d = (d_rd || d_wr) && !(i_req && m_run == int'(MDR));
                if (!m_own_d) m_run = 0;
                else m_run = i_req ? m_run + 1 : 0;
`else
                m_own_d = d_rd || d_wr;
`endif
                m_busy  = 1'b1;
                m_addr  = m_own_d ? d_addr : i_addr;
                m_wr    = m_own_d && d_wr;
                m_wdata = m_own_d ? d_wdata : '0;
                m_issue = cyc + 1;
                m_acc   = -1;
            end

            exp_en = m_busy && (cyc >= m_issue) && (m_acc < 0);
            n_checks++;
            if (mem_en !== exp_en) begin
                n_errors++;
                $display("FAIL rnd_mem_en cyc=%0d got %b want %b", cyc, mem_en, exp_en);
            end
            if (exp_en && mem_ready) begin
                m_acc = cyc;
                m_rdexp = mem[m_addr[7:0]];
                n_checks++;
                if ({mem_wr, mem_addr} !== {m_wr, m_addr}) begin
                    n_errors++;
                    $display("FAIL rnd_cmd cyc=%0d got %b %h want %b %h", cyc, mem_wr, mem_addr,
                             m_wr, m_addr);
                end
                if (m_wr) begin
                    n_checks++;
                    if (mem_wdata !== m_wdata) begin
                        n_errors++;
                        $display("FAIL rnd_wdata cyc=%0d got %h want %h", cyc, mem_wdata,
                                 m_wdata);
                    end
                end
            end

            exp_idone = m_busy && (m_acc >= 0) && (cyc == m_acc + int'(LAT)) && !m_own_d;
            exp_ddone = m_busy && (m_acc >= 0) && (cyc == m_acc + int'(LAT)) && m_own_d;
            if (exp_idone) exp_i_rdata = m_rdexp;
            if (exp_ddone && !m_wr) exp_d_rdata = m_rdexp;

            n_checks++;
            if ({i_done, d_done} !== {exp_idone, exp_ddone}) begin
                n_errors++;
                $display("FAIL rnd_done cyc=%0d got i%b d%b want i%b d%b", cyc, i_done, d_done,
                         exp_idone, exp_ddone);
            end
            n_checks++;
            if ({i_rdata, d_rdata} !== {exp_i_rdata, exp_d_rdata}) begin
                n_errors++;
                $display("FAIL rnd_rdata cyc=%0d got %h %h want %h %h", cyc, i_rdata, d_rdata,
                         exp_i_rdata, exp_d_rdata);
            end
            n_checks++;
            if ({i_stall, d_stall} !== {i_req & ~exp_idone, (d_rd | d_wr) & ~exp_ddone}) begin
                n_errors++;
                $display("FAIL rnd_stall cyc=%0d got %b%b want %b%b", cyc, i_stall, d_stall,
                         i_req & ~exp_idone, (d_rd | d_wr) & ~exp_ddone);
            end

            if (exp_idone) drop_i = 1'b1;
            if (exp_ddone) drop_d = 1'b1;
            if (exp_idone || exp_ddone) m_busy = 1'b0;
        end
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; mem_ready = 1'b1;
        for (int t = 0; t < 10; t++) tick();
    endtask

    initial begin
        rst = 1'b0; i_req = 1'b0; i_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ready = 1'b1; mem_rdata = '0;
        for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
        test_reset();
        test_single_read();
        test_d_priority();
        test_ready_stall();
        test_reset_mid();
        test_rdwr_both();
        test_arbitration();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
